// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared state encoding, bit-reflect helper and CRC presets
package crc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } crc_state_t;

   localparam logic [31:0] CRC32_ETH_POLY    = 32'h04C1_1DB7;
   localparam logic [31:0] CRC32_ETH_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_ETH_XOROUT  = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_ETH_CHECK   = 32'h2144_DF1C;
   localparam bit          CRC32_ETH_REFIN   = 1'b1;
   localparam bit          CRC32_ETH_REFOUT  = 1'b1;

   localparam logic [31:0] CRC16_CCITT_POLY   = 32'h0000_1021;
   localparam logic [31:0] CRC16_CCITT_INIT   = 32'h0000_FFFF;
   localparam logic [31:0] CRC16_CCITT_XOROUT = 32'h0000_0000;
   localparam logic [31:0] CRC16_CCITT_CHECK  = 32'h0000_0000;
   localparam bit          CRC16_CCITT_REFIN  = 1'b0;
   localparam bit          CRC16_CCITT_REFOUT = 1'b0;

   localparam logic [31:0] CRC8_POLY   = 32'h0000_0007;
   localparam logic [31:0] CRC8_INIT   = 32'h0000_0000;
   localparam logic [31:0] CRC8_XOROUT = 32'h0000_0000;
   localparam logic [31:0] CRC8_CHECK  = 32'h0000_0000;
   localparam bit          CRC8_REFIN  = 1'b0;
   localparam bit          CRC8_REFOUT = 1'b0;

   // Reverse the low w bits of v; bits at and above w come back as zero.
   function automatic logic [31:0] crc_reflect(input logic [31:0] v, input int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < w) r[i] = v[5'(w - 1 - i)];
      end
      return r;
   endfunction

endpackage

// File: rtl/crc_step.sv
// rtl/crc_step.sv - combinational DATA_W-bit CRC advance, normal (MSB-shift) form
module crc_step
   import crc_pkg::*;
#(
   parameter int          CRC_W  = 32,
   parameter int          DATA_W = 8,
   parameter logic [31:0] POLY   = 32'h04C1_1DB7,
   parameter bit          REFIN  = 1'b1
) (
   input  logic [CRC_W-1:0]  crc_in,
   input  logic [DATA_W-1:0] data,
   output logic [CRC_W-1:0]  crc_out
);

   localparam logic [CRC_W-1:0] POLY_W = POLY[CRC_W-1:0];

   logic [CRC_W-1:0] c;
   logic             d;
   logic             fb;

   // Unrolled bit-steps; REFIN only changes which end of the beat is fed first.
   always_comb begin
      c  = crc_in;
      d  = 1'b0;
      fb = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         d  = REFIN ? data[i] : data[DATA_W-1-i];
         fb = c[CRC_W-1] ^ d;
         c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY_W : '0);
      end
      crc_out = c;
   end

endmodule

// File: rtl/crc_engine.sv
// rtl/crc_engine.sv - framed CRC generator/checker with valid/ready result handshake
// Optional residue compare on crc_ok enabled by defining CRC_CHECK_EN.
module crc_engine
   import crc_pkg::*;
#(
   parameter int          CRC_W  = 32,
   parameter int          DATA_W = 8,
   parameter logic [31:0] POLY   = CRC32_ETH_POLY,
   parameter logic [31:0] INIT   = CRC32_ETH_INIT,
   parameter bit          REFIN  = 1'b1,
   parameter bit          REFOUT = 1'b1,
   parameter logic [31:0] XOROUT = CRC32_ETH_XOROUT,
   parameter logic [31:0] CHECK  = CRC32_ETH_CHECK
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CRC_W-1:0]  o_crc,
   output logic              crc_ok
);

   localparam logic [CRC_W-1:0] INIT_W   = INIT[CRC_W-1:0];
   localparam logic [CRC_W-1:0] XOROUT_W = XOROUT[CRC_W-1:0];

   crc_state_t       state;
   crc_state_t       state_nxt;
   logic             beat;
   logic [CRC_W-1:0] crc_ff;
   logic [CRC_W-1:0] step_in;
   logic [CRC_W-1:0] step_out;
   logic [31:0]      step_refl;
   logic [CRC_W-1:0] final_crc;

   assign beat = in_valid & in_ready;

   // Only a beat in RUN continues the frame; IDLE and a back-to-back DONE start fresh.
   assign step_in = (state == ST_RUN) ? crc_ff : INIT_W;

   crc_step #(
      .CRC_W  (CRC_W),
      .DATA_W (DATA_W),
      .POLY   (POLY),
      .REFIN  (REFIN)
   ) u_step (
      .crc_in  (step_in),
      .data    (in_data),
      .crc_out (step_out)
   );

   assign step_refl = crc_reflect(32'(step_out), CRC_W);
   assign final_crc = (REFOUT ? step_refl[CRC_W-1:0] : step_out) ^ XOROUT_W;

   always_ff @(posedge CLK) begin
      if (RST) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (beat) state_nxt = in_last ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (beat && in_last) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               if (beat) state_nxt = in_last ? ST_DONE : ST_RUN;
               else      state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state != ST_DONE) | out_ready;
      out_valid = (state == ST_DONE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         crc_ff <= INIT_W;
         o_crc  <= '0;
      end else if (beat) begin
         crc_ff <= step_out;
         if (in_last) o_crc <= final_crc;
      end
   end

`ifdef CRC_CHECK_EN
   localparam logic [CRC_W-1:0] CHECK_W = CHECK[CRC_W-1:0];

   always_ff @(posedge CLK) begin
      if (RST)                   crc_ok <= 1'b0;
      else if (beat && in_last)  crc_ok <= (final_crc == CHECK_W);
   end
`else
   assign crc_ok = 1'b0;
`endif

endmodule
